// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 read-channel constants shared by bus masters
package axi4_pkg;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V front-end types
package riscv_pkg;
  typedef enum logic [2:0] {FETCH, WAIT, EMIT, DROP, HALT} ifu_state_t;
endpackage

// File: rtl/riscv_ifu.sv
// riscv_ifu: AXI4 instruction fetch unit with compressed-instruction parcel buffer
module riscv_ifu
  import riscv_pkg::*, axi4_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_addr,
  output logic        ifu_vld,
  output logic [31:0] ifu_addr,
  output logic [31:0] ifu_data,
  output logic        ifu_fault,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  output logic [31:0] ifu_araddr,
  output logic [2:0]  ifu_arprot,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp
);
  ifu_state_t r_state;
  logic [31:0] r_pc, r_faddr, r_addr, r_data;
  logic [31:1] r_tgt;
  logic [47:0] r_buf;
  logic [1:0]  r_cnt;
  logic        r_skip, r_rdp, r_vld, r_fault;
  logic        w_rok, w_act, w_c16, w_can, w_emit, w_fault, w_arhs, w_apply, w_unused;
  logic [47:0] w_in, w_view;
  logic [1:0]  w_vcnt, w_use;
  logic [5:0]  w_sh;
  logic [31:1] w_tgt;
  logic [31:0] w_ins;
  assign ifu_vld     = r_vld;
  assign ifu_addr    = r_addr;
  assign ifu_data    = r_data;
  assign ifu_fault   = r_fault;
  assign ifu_arvalid = !reset && r_state == FETCH;
  assign ifu_araddr  = r_faddr;
  assign ifu_arprot  = AXI_PROT_INSTR;
  assign ifu_rready  = r_state == WAIT || r_state == DROP;
  assign w_unused    = redirect_addr[0];
  // The returning beat is merged into a view of the buffer so it can be emitted the cycle after the R handshake
  always_comb begin
    w_rok   = ifu_rvalid && ifu_rresp == AXI_RESP_OKAY;
    w_in    = r_skip ? {32'h0, ifu_rdata[31:16]} : {16'h0, ifu_rdata};
    w_view  = r_state == WAIT ? r_buf | (w_in << {r_cnt, 4'b0}) : r_buf;
    w_vcnt  = r_state == WAIT ? r_cnt + (r_skip ? 2'd1 : 2'd2) : r_cnt;
    w_c16   = w_view[1:0] != 2'b11;
    w_use   = w_c16 ? 2'd1 : 2'd2;
    w_sh    = w_c16 ? 6'd16 : 6'd32;
    w_can   = w_vcnt != 2'd0 && (w_c16 || w_vcnt >= 2'd2);
    w_act   = !redirect_vld && (r_state == EMIT || (r_state == WAIT && w_rok));
    w_emit  = w_act && w_can;
    w_fault = r_state == WAIT && ifu_rvalid && !w_rok && !redirect_vld;
    w_ins   = w_c16 ? {16'h0, w_view[15:0]} : w_view[31:0];
    w_arhs  = ifu_arvalid && ifu_arready;
    w_tgt   = redirect_vld ? redirect_addr[31:1] : r_tgt;
    w_apply = (redirect_vld && (r_state == EMIT || r_state == HALT)) ||
              (ifu_rvalid && (r_state == DROP || (r_state == WAIT && redirect_vld)));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_ADDR;
      r_faddr <= RESET_ADDR;
      r_tgt   <= '0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_skip  <= 1'b0;
      r_rdp   <= 1'b0;
      r_vld   <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_vld   <= w_emit || w_fault;
      r_fault <= w_fault;
      r_addr  <= r_pc;
      r_data  <= w_emit ? w_ins : 32'h0;
      if (redirect_vld) r_tgt <= redirect_addr[31:1];
      if (w_apply) begin
        r_state <= FETCH;
        r_pc    <= {w_tgt, 1'b0};
        r_faddr <= {w_tgt[31:2], 2'b00};
        r_skip  <= w_tgt[1];
        r_buf   <= '0;
        r_cnt   <= '0;
        r_rdp   <= 1'b0;
      end else if (r_state == FETCH) begin
        r_rdp <= !w_arhs && (r_rdp || redirect_vld);
        if (w_arhs) begin
          r_faddr <= r_faddr + 32'd4;
          r_state <= (r_rdp || redirect_vld) ? DROP : WAIT;
        end
      end else if (w_fault) begin
        r_state <= HALT;
      end else if (r_state == WAIT && redirect_vld) begin
        r_state <= DROP;
      end else if (w_act) begin
        r_skip  <= 1'b0;
        r_state <= w_can ? EMIT : FETCH;
        r_buf   <= w_can ? w_view >> w_sh : w_view;
        r_cnt   <= w_can ? w_vcnt - w_use : w_vcnt;
        if (w_can) r_pc <= r_pc + {29'h0, w_use, 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_riscv_ifu.sv
// tb_riscv_ifu: directed-vector bench with a small AXI4 read slave and emit/AR logs
module tb_riscv_ifu;
  logic        clock = 1'b0, reset = 1'b1, redirect_vld = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        ifu_vld, ifu_fault, ifu_arvalid, ifu_rready;
  logic [31:0] ifu_addr, ifu_data, ifu_araddr;
  logic [2:0]  ifu_arprot;
  logic        ifu_arready = 1'b0, ifu_rvalid = 1'b0;
  logic [31:0] ifu_rdata = 32'h0;
  logic [1:0]  ifu_rresp = 2'b00;
  int n_cmp = 0, n_bad = 0;
  int stall = 0, rlat = 0;
  logic err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ev_a[$], ev_d[$], ar_q[$];
  logic        ev_f[$];

  riscv_ifu #(.RESET_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset), .redirect_vld(redirect_vld), .redirect_addr(redirect_addr),
    .ifu_vld(ifu_vld), .ifu_addr(ifu_addr), .ifu_data(ifu_data), .ifu_fault(ifu_fault),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arprot(ifu_arprot), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Samples handshakes at the falling edge, updates slave drives just after the rising edge
  initial begin : slave
    logic hs_ar, hs_r, pst, pend;
    logic [31:0] a, pa, paddr;
    int dly;
    pst = 0; pend = 0; pa = 0; paddr = 0; dly = 0;
    forever begin
      @(negedge clock);
      hs_ar = ifu_arvalid && ifu_arready;
      hs_r  = ifu_rvalid && ifu_rready;
      a     = ifu_araddr;
      if (ifu_vld && !reset) begin
        ev_a.push_back(ifu_addr); ev_d.push_back(ifu_data); ev_f.push_back(ifu_fault);
      end
      if (pst && !reset) begin
        check("ar_hold", {31'h0, ifu_arvalid}, 32'h1);
        check("ar_stable", a, pa);
      end
      pst = ifu_arvalid && !ifu_arready;
      pa  = a;
      @(posedge clock);
      #1;
      if (reset) begin
        ifu_arready = 0; ifu_rvalid = 0; pend = 0; pst = 0;
      end else begin
        if (hs_r) ifu_rvalid = 0;
        if (hs_ar) begin
          ar_q.push_back(a); pend = 1; paddr = a; dly = rlat;
        end
        if (pend && !ifu_rvalid) begin
          if (dly > 0) dly--;
          else begin
            ifu_rvalid = 1;
            ifu_rdata  = mem.exists(paddr) ? mem[paddr] : 32'h0;
            ifu_rresp  = (err_en && paddr == err_addr) ? 2'b10 : 2'b00;
            pend = 0;
          end
        end
        ifu_arready = stall == 0;
        if (stall > 0) stall--;
      end
    end
  end

  task automatic do_reset(input int st);
    reset = 1; redirect_vld = 0; rlat = 0; err_en = 0; stall = st;
    ev_a.delete(); ev_d.delete(); ev_f.delete(); ar_q.delete();
    repeat (3) @(posedge clock);
    #2;
    check("rst_vld", {31'h0, ifu_vld}, 32'h0);
    check("rst_fault", {31'h0, ifu_fault}, 32'h0);
    check("rst_rready", {31'h0, ifu_rready}, 32'h0);
    check("rst_arvalid", {31'h0, ifu_arvalid}, 32'h0);
    reset = 0;
    @(negedge clock);
    check("arvalid_up", {31'h0, ifu_arvalid}, 32'h1);
    check("araddr_rst", ifu_araddr, 32'h0);
    check("arprot", {29'h0, ifu_arprot}, 32'h4);
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_addr = a; redirect_vld = 1;
    @(posedge clock);
    #2;
    redirect_vld = 0;
  endtask

  task automatic wait_ev(input string tag, input int n);
    for (int i = 0; i < 300 && ev_a.size() < n; i++) begin
      @(posedge clock);
      #2;
    end
    check(tag, {31'h0, ev_a.size() >= n}, 32'h1);
  endtask

  task automatic wait_ar(input string tag, input int n);
    for (int i = 0; i < 300 && ar_q.size() < n; i++) begin
      @(posedge clock);
      #2;
    end
    check(tag, {31'h0, ar_q.size() >= n}, 32'h1);
  endtask

  task automatic chk_ev(input string tag, input int i, input logic [31:0] a, input logic [31:0] d, input logic f);
    check({tag, "_addr"}, i < ev_a.size() ? ev_a[i] : 32'hx, a);
    check({tag, "_data"}, i < ev_d.size() ? ev_d[i] : 32'hx, d);
    check({tag, "_fault"}, i < ev_f.size() ? {31'h0, ev_f[i]} : 32'hx, {31'h0, f});
  endtask

  task automatic chk_ar(input string tag, input int i, input logic [31:0] a);
    check(tag, i < ar_q.size() ? ar_q[i] : 32'hx, a);
  endtask

  initial begin
    mem.delete(); mem[32'h0] = 32'h0010_0093;
    do_reset(0);
    wait_ev("t1_n", 1);
    chk_ev("t1", 0, 32'h0, 32'h0010_0093, 1'b0);
    chk_ar("t1_ar", 0, 32'h0);

    mem.delete(); mem[32'h0] = 32'h4505_0001;
    do_reset(0);
    wait_ev("t2_n", 2);
    chk_ev("t2a", 0, 32'h0, 32'h0000_0001, 1'b0);
    chk_ev("t2b", 1, 32'h2, 32'h0000_4505, 1'b0);
    wait_ar("t2_arn", 2);
    chk_ar("t2_ar1", 1, 32'h4);

    mem.delete(); mem[32'h0] = 32'h0093_0001; mem[32'h4] = 32'h0000_0010;
    do_reset(0);
    wait_ev("t3_n", 3);
    chk_ev("t3a", 0, 32'h0, 32'h0000_0001, 1'b0);
    chk_ev("t3b", 1, 32'h2, 32'h0010_0093, 1'b0);
    chk_ev("t3c", 2, 32'h6, 32'h0000_0000, 1'b0);
    chk_ar("t3_ar1", 1, 32'h4);

    mem.delete(); mem[32'h0] = 32'h0010_0093; mem[32'h100] = 32'h0001_FFFF;
    do_reset(0);
    rlat = 3;
    wait_ar("t4_arn", 1);
    redirect(32'h0000_0102);
    wait_ev("t4_n", 1);
    chk_ev("t4", 0, 32'h102, 32'h0000_0001, 1'b0);
    chk_ar("t4_ar1", 1, 32'h100);

    mem.delete(); mem[32'h0] = 32'h0001_0001; mem[32'h4] = 32'h0001_0001; mem[32'h20] = 32'h0010_0093;
    do_reset(0);
    err_en = 1; err_addr = 32'h8;
    wait_ev("t5_n", 5);
    chk_ev("t5a", 0, 32'h0, 32'h1, 1'b0);
    chk_ev("t5d", 3, 32'h6, 32'h1, 1'b0);
    chk_ev("t5f", 4, 32'h8, 32'h0, 1'b1);
    repeat (10) @(posedge clock);
    #2;
    check("t5_halt_ar", ar_q.size(), 32'd3);
    check("t5_halt_ev", ev_a.size(), 32'd5);
    check("t5_halt_arv", {31'h0, ifu_arvalid}, 32'h0);
    redirect(32'h20);
    wait_ev("t5_rn", 6);
    chk_ev("t5r", 5, 32'h20, 32'h0010_0093, 1'b0);
    chk_ar("t5_ar3", 3, 32'h20);

    mem.delete(); mem[32'h0] = 32'h0010_0093; mem[32'h40] = 32'h0001_0001;
    do_reset(5);
    @(posedge clock);
    #2;
    redirect(32'h40);
    wait_ev("t6_n", 1);
    chk_ev("t6", 0, 32'h40, 32'h1, 1'b0);
    chk_ar("t6_ar0", 0, 32'h0);
    chk_ar("t6_ar1", 1, 32'h40);

    mem.delete(); mem[32'h0] = 32'h0010_0093; mem[32'h300] = 32'h0001_0001;
    do_reset(0);
    rlat = 3;
    wait_ar("t7_arn", 1);
    redirect(32'h200);
    redirect(32'h300);
    wait_ev("t7_n", 1);
    chk_ev("t7", 0, 32'h300, 32'h1, 1'b0);
    chk_ar("t7_ar1", 1, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
